// File: rtl/mul_pkg.sv
// Shared types and helpers for the iterative RV32M/RV64M multiply unit.
package mul_pkg;

  typedef enum logic [1:0] {
    MUL    = 2'b00,
    MULH   = 2'b01,
    MULHSU = 2'b10,
    MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } mul_state_e;

  // {rs1_signed, rs2_signed}; MUL keeps only the low half, which is sign-agnostic.
  function automatic logic [1:0] op_signed(input mul_op_e op);
    case (op)
      MULH:    return 2'b11;
      MULHSU:  return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/mul_step.sv
// One shift-add iteration: adds mcand * digit, shifted left by shift, to the accumulator.
module mul_step #(
  parameter int XLEN = 32,
  parameter int BPC  = 4,
  parameter int SW   = (XLEN > 1) ? $clog2(XLEN) : 1
) (
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   mcand,
  input  logic [BPC-1:0]    digit,
  input  logic [SW-1:0]     shift,
  output logic [2*XLEN-1:0] acc_out
);

  localparam int AW = 2 * XLEN;

  logic [AW-1:0] w_pp;

  always_comb begin
    w_pp    = {{XLEN{1'b0}}, mcand} * {{(AW-BPC){1'b0}}, digit};
    acc_out = acc_in + (w_pp << shift);
  end

endmodule

// File: rtl/mul_iter.sv
// Iterative multiply unit: magnitudes are multiplied BPC bits per cycle, then the
// sign is applied and the requested half is presented with its reservation tag.
module mul_iter
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int BPC   = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  Vj,
  input  logic [XLEN-1:0]  Vk,
  input  logic [9:0]       Op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  y,
  output logic [TAG_W-1:0] out_tag
);

  localparam int N  = XLEN / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam int AW = 2 * XLEN;

  mul_state_e       r_state;
  mul_op_e          r_op;
  logic [XLEN-1:0]  r_ma;
  logic [XLEN-1:0]  r_mb;
  logic [AW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_neg;
  logic [TAG_W-1:0] r_tag;
  logic [XLEN-1:0]  r_y;
  logic [TAG_W-1:0] r_out_tag;
  logic             r_out_valid;

  mul_op_e          w_op;
  logic [1:0]       w_sgn;
  logic             w_sa;
  logic             w_sb;
  logic             w_accept;
  logic             w_last;
  logic [SW-1:0]    w_shift;
  logic [AW-1:0]    w_acc_next;
  logic [AW-1:0]    w_fixed;
  logic [XLEN-1:0]  w_result;
  logic             w_unused_op;

  assign w_op        = mul_op_e'(Op[8:7]);
  assign w_unused_op = ^{Op[9], Op[6:0]};
  assign w_sgn       = op_signed(w_op);
  assign w_sa        = w_sgn[1] & Vj[XLEN-1];
  assign w_sb        = w_sgn[0] & Vk[XLEN-1];

  assign in_ready = !flush & ((r_state == IDLE) | ((r_state == DONE) & out_ready));
  assign w_accept = in_valid & in_ready;
  assign w_last   = (r_cnt == CW'(N - 1));
  assign w_shift  = SW'(int'(r_cnt) * BPC);

  // r_mb shifts right each iteration, so the next digit is always its low BPC bits.
  mul_step #(
    .XLEN (XLEN),
    .BPC  (BPC),
    .SW   (SW)
  ) u_step (
    .acc_in  (r_acc),
    .mcand   (r_ma),
    .digit   (r_mb[BPC-1:0]),
    .shift   (w_shift),
    .acc_out (w_acc_next)
  );

  assign w_fixed  = r_neg ? -r_acc : r_acc;
  assign w_result = (r_op == MUL) ? w_fixed[XLEN-1:0] : w_fixed[AW-1:XLEN];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= MUL;
      r_ma        <= '0;
      r_mb        <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_tag       <= '0;
      r_y         <= '0;
      r_out_tag   <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      // Covers both IDLE and the back-to-back retire+accept from DONE.
      r_state     <= BUSY;
      r_op        <= w_op;
      r_ma        <= w_sa ? -Vj : Vj;
      r_mb        <= w_sb ? -Vk : Vk;
      r_neg       <= w_sa ^ w_sb;
      r_tag       <= in_tag;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        BUSY: begin
          r_acc <= w_acc_next;
          r_mb  <= r_mb >> BPC;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_state <= FIX;
        end
        FIX: begin
          r_y         <= w_result;
          r_out_tag   <= r_tag;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign y         = r_y;
  assign out_tag   = r_out_tag;

endmodule
